// File: rtl/rps_pkg.sv
// Shared move encoding, referee FSM states and scoring helpers for the
// rock-paper-scissors referee and predictors.
package rps_pkg;

  localparam logic [1:0] ROCK    = 2'b00;
  localparam logic [1:0] SCISSOR = 2'b01;
  localparam logic [1:0] PAPER   = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_JUDGE,
    ST_SHOW
  } ref_state_e;

  function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
    return ((a == ROCK)    && (b == SCISSOR)) ||
           ((a == SCISSOR) && (b == PAPER))   ||
           ((a == PAPER)   && (b == ROCK));
  endfunction

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99)
      r = s;
    else if (s[3:0] == 4'd9)
      r = {s[7:4] + 4'd1, 4'd0};
    else
      r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted press (debounced 1->0).
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync2;
        r_press <= ~r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/round_referee.sv
// Round sequencer and scorer: debounced start key, user latch, computer-move
// handshake with timeout fallback, judging and BCD scores.
module round_referee
  import rps_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned COM_TIMEOUT     = 1024,
  parameter logic [1:0]  FALLBACK_MOVE   = 2'b00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_n,
  input  logic [1:0] user,
  output logic       com_req,
  input  logic       com_valid,
  input  logic [1:0] com,
  output logic [1:0] com_shown,
  output logic [1:0] user_shown,
  output logic [7:0] user_score,
  output logic [7:0] com_score,
  output logic       uwin,
  output logic       cwin,
  output logic       draw,
  output logic       invalid,
  output logic       timeout,
  output logic       round_done,
  output logic       hist_valid,
  output logic [1:0] hist_user,
  output logic [1:0] hist_com
);

  localparam int unsigned TW = (COM_TIMEOUT > 1) ? $clog2(COM_TIMEOUT) : 1;
  localparam logic [TW-1:0] WAIT_LAST = TW'(COM_TIMEOUT - 1);

  logic          w_level;
  logic          w_press;
  ref_state_e    r_state;
  ref_state_e    w_state_nx;
  logic [TW-1:0] r_wait;
  logic [1:0]    r_u_lat;
  logic          w_latch_user, w_bad_user, w_start_req, w_bad_com;
  logic          w_judge, w_timeout;
  logic [1:0]    w_c_move;
  logic          w_uwin, w_draw;

  logic [1:0] r_com_shown, r_user_shown, r_hist_user, r_hist_com;
  logic [7:0] r_user_score, r_com_score;
  logic       r_uwin, r_cwin, r_draw, r_invalid, r_timeout;
  logic       r_round_done, r_hist_valid;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_key (
    .clock (clock),
    .reset (reset),
    .key_n (start_n),
    .level (w_level),
    .press (w_press)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_latch_user = 1'b0;
    w_bad_user   = 1'b0;
    w_start_req  = 1'b0;
    w_bad_com    = 1'b0;
    w_judge      = 1'b0;
    w_timeout    = 1'b0;
    w_c_move     = com;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_latch_user = 1'b1;
          if (user == INVALID) begin
            w_bad_user = 1'b1;
          end else begin
            w_start_req = 1'b1;
            w_state_nx  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (com_valid) begin
          if (com == INVALID) begin
            w_bad_com  = 1'b1;
            w_state_nx = ST_IDLE;
          end else begin
            w_judge    = 1'b1;
            w_state_nx = ST_JUDGE;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_judge    = 1'b1;
          w_timeout  = 1'b1;
          w_c_move   = FALLBACK_MOVE;
          w_state_nx = ST_JUDGE;
        end
      end
      ST_JUDGE: w_state_nx = ST_SHOW;
      ST_SHOW:  if (w_level) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
    com_req = (r_state == ST_REQ);
    w_uwin  = beats(r_u_lat, w_c_move);
    w_draw  = (r_u_lat == w_c_move);
  end

  // Results are registered on the edge entering JUDGE, so JUDGE is the cycle
  // in which the updated scores and the round_done pulse are visible together.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait       <= '0;
      r_u_lat      <= '0;
      r_com_shown  <= '0;
      r_user_shown <= '0;
      r_hist_user  <= '0;
      r_hist_com   <= '0;
      r_user_score <= '0;
      r_com_score  <= '0;
      r_uwin       <= 1'b0;
      r_cwin       <= 1'b0;
      r_draw       <= 1'b0;
      r_invalid    <= 1'b0;
      r_timeout    <= 1'b0;
      r_round_done <= 1'b0;
      r_hist_valid <= 1'b0;
    end else begin
      r_round_done <= 1'b0;
      r_hist_valid <= 1'b0;
      r_wait       <= (r_state == ST_REQ) ? r_wait + 1'b1 : '0;
      if (w_latch_user) r_u_lat <= user;
      if (w_bad_user) begin
        r_invalid <= 1'b1;
        r_timeout <= 1'b0;
      end
      if (w_start_req) begin
        r_invalid <= 1'b0;
        r_timeout <= 1'b0;
      end
      if (w_bad_com) r_invalid <= 1'b1;
      if (w_judge) begin
        r_timeout    <= w_timeout;
        r_uwin       <= w_uwin;
        r_draw       <= w_draw;
        r_cwin       <= ~w_uwin & ~w_draw;
        r_user_shown <= r_u_lat;
        r_com_shown  <= w_c_move;
        r_hist_user  <= r_u_lat;
        r_hist_com   <= w_c_move;
        r_round_done <= 1'b1;
        r_hist_valid <= 1'b1;
        if (w_uwin)
          r_user_score <= bcd_inc(r_user_score);
        else if (!w_draw)
          r_com_score <= bcd_inc(r_com_score);
      end
    end
  end

  assign com_shown  = r_com_shown;
  assign user_shown = r_user_shown;
  assign user_score = r_user_score;
  assign com_score  = r_com_score;
  assign uwin       = r_uwin;
  assign cwin       = r_cwin;
  assign draw       = r_draw;
  assign invalid    = r_invalid;
  assign timeout    = r_timeout;
  assign round_done = r_round_done;
  assign hist_valid = r_hist_valid;
  assign hist_user  = r_hist_user;
  assign hist_com   = r_hist_com;

endmodule

// File: tb/tb_round_referee.sv
// Randomised bench for round_referee against a round-level scoring model
// (integer scores, modular win rule, cycle-count expectations).
module tb_round_referee;

  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 8;

  logic       clock = 1'b0;
  logic       reset, start_n, com_valid;
  logic [1:0] user, com;
  logic       com_req;
  logic [1:0] com_shown, user_shown, hist_user, hist_com;
  logic [7:0] user_score, com_score;
  logic       uwin, cwin, draw, invalid, timeout, round_done, hist_valid;

  int n_cmp = 0;
  int n_err = 0;

  int         m_us, m_cs;
  logic       m_uw, m_cw, m_dr, m_inv, m_to;
  logic [1:0] m_ushown, m_cshown, m_hu, m_hc;

  always #5 clock = ~clock;

  round_referee #(
    .DEBOUNCE_CYCLES (DEB),
    .COM_TIMEOUT     (TMO),
    .FALLBACK_MOVE   (2'b00)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start_n    (start_n),
    .user       (user),
    .com_req    (com_req),
    .com_valid  (com_valid),
    .com        (com),
    .com_shown  (com_shown),
    .user_shown (user_shown),
    .user_score (user_score),
    .com_score  (com_score),
    .uwin       (uwin),
    .cwin       (cwin),
    .draw       (draw),
    .invalid    (invalid),
    .timeout    (timeout),
    .round_done (round_done),
    .hist_valid (hist_valid),
    .hist_user  (hist_user),
    .hist_com   (hist_com)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  function automatic logic [7:0] bcd(input int x);
    int y;
    y = (x > 99) ? 99 : x;
    return 8'((y / 10) * 16 + (y % 10));
  endfunction

  // 0 = draw, 1 = user wins, 2 = computer wins (rock 0 beats scissor 1 beats paper 2 beats rock)
  function automatic int outcome(input int u, input int c);
    if (u == c) return 0;
    if (c == (u + 1) % 3) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_us = 0; m_cs = 0;
    m_uw = 0; m_cw = 0; m_dr = 0; m_inv = 0; m_to = 0;
    m_ushown = 0; m_cshown = 0; m_hu = 0; m_hc = 0;
  endtask

  task automatic model_round(input logic [1:0] u, input logic [1:0] c, input logic to);
    int o;
    o = outcome(int'(u), int'(c));
    m_uw = (o == 1); m_cw = (o == 2); m_dr = (o == 0);
    if (o == 1) m_us++;
    if (o == 2) m_cs++;
    m_ushown = u; m_cshown = c; m_hu = u; m_hc = c; m_to = to;
  endtask

  task automatic check_state();
    chk("uwin", uwin, m_uw);
    chk("cwin", cwin, m_cw);
    chk("draw", draw, m_dr);
    chk("invalid", invalid, m_inv);
    chk("timeout", timeout, m_to);
    chk("user_shown", user_shown, m_ushown);
    chk("com_shown", com_shown, m_cshown);
    chk("user_score", user_score, bcd(m_us));
    chk("com_score", com_score, bcd(m_cs));
    chk("hist_user", hist_user, m_hu);
    chk("hist_com", hist_com, m_hc);
  endtask

  // One press with user move u. Computer answers c after d REQ cycles;
  // d < 0 or d >= TMO means it never answers. Key stays held hold extra cycles.
  task automatic play(input logic [1:0] u, input logic [1:0] c, input int d, input int hold);
    int n, req_cycles, n_act;
    bit give;
    user = u;
    start_n = 1'b0;
    if (u == 2'b11) begin
      n_act = 0;
      repeat (20) begin
        cyc();
        if (com_req || round_done) n_act++;
      end
      chk("req_on_bad_user", n_act, 0);
      m_inv = 1; m_to = 0;
      check_state();
    end else begin
      n = 0;
      while (!com_req && n < 20) begin
        cyc();
        n++;
      end
      chk("press_latency", n, DEB + 3);
      m_inv = 0; m_to = 0;
      req_cycles = 1;
      for (int k = 0; k < int'(TMO) + 4; k++) begin
        if (k == d) begin
          com_valid = 1'b1;
          com = c;
        end
        cyc();
        com_valid = 1'b0;
        com = 2'($urandom);
        if (!com_req) break;
        req_cycles++;
      end
      give = (d >= 0) && (d < int'(TMO));
      chk("req_cycles", req_cycles, give ? d + 1 : int'(TMO));
      if (give && c == 2'b11) begin
        m_inv = 1;
        chk("rd_on_bad_com", round_done, 0);
        check_state();
      end else begin
        model_round(u, give ? c : 2'b00, !give);
        chk("round_done", round_done, 1);
        chk("hist_valid", hist_valid, 1);
        check_state();
        cyc();
        chk("rd_pulse_end", round_done, 0);
      end
    end
    n_act = 0;
    repeat (hold) begin
      com_valid = 1'($urandom);
      cyc();
      if (com_req || round_done) n_act++;
    end
    com_valid = 1'b0;
    chk("no_second_round", n_act, 0);
    start_n = 1'b1;
    repeat (DEB + 6) cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n_act, d, u, c;
    reset = 1'b1; start_n = 1'b1; user = 2'b00; com_valid = 1'b0; com = 2'b00;
    model_reset();
    repeat (3) cyc();
    check_state();
    chk("reset_com_req", com_req, 0);
    chk("reset_round_done", round_done, 0);
    chk("reset_hist_valid", hist_valid, 0);
    reset = 1'b0;
    cyc();

    play(2'b00, 2'b01, 0, 0);

    // Short glitch on the key must not register as a press.
    start_n = 1'b0;
    repeat (3) cyc();
    start_n = 1'b1;
    n_act = 0;
    repeat (20) begin
      cyc();
      if (com_req || round_done) n_act++;
    end
    chk("glitch_ignored", n_act, 0);

    play(2'($urandom_range(0, 2)), 2'($urandom_range(0, 2)), int'($urandom_range(0, 5)), 100);
    play(2'b11, 2'b00, 0, 0);
    play(2'b10, 2'b10, 0, 0);
    play(2'b10, 2'b01, -1, 0);
    play(2'b01, 2'b11, 2, 0);
    play(2'b00, 2'b10, int'(TMO) - 1, 0);

    for (int r = 0; r < 40; r++) begin
      u = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      c = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      d = int'($urandom_range(0, 9)) - 1;
      play(2'(u), 2'(c), d, int'($urandom_range(0, 3)));
    end

    // Drive the user score through every carry up to and past saturation.
    while (m_us <= 100) begin
      u = int'($urandom_range(0, 2));
      play(2'(u), 2'((u + 1) % 3), int'($urandom_range(0, 6)), 0);
    end

    // Reset during REQ aborts the round.
    user = 2'b00;
    start_n = 1'b0;
    n_act = 0;
    while (!com_req && n_act < 20) begin
      cyc();
      n_act++;
    end
    chk("req_before_reset", com_req, 1);
    reset = 1'b1;
    start_n = 1'b1;
    cyc();
    model_reset();
    chk("reset_drops_req", com_req, 0);
    chk("reset_rd", round_done, 0);
    chk("reset_hv", hist_valid, 0);
    check_state();
    reset = 1'b0;
    cyc();
    com_valid = 1'b1;
    com = 2'b01;
    cyc();
    com_valid = 1'b0;
    n_act = 0;
    repeat (20) begin
      cyc();
      if (com_req || round_done) n_act++;
    end
    chk("late_valid_ignored", n_act, 0);
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/round_referee.md
Name: round_referee

Overview:
- Round sequencer and scorer for the rock-paper-scissors game.
- Sits between the board keys/switches and the computer-player predictors: debounces the start key, latches the user move, requests and waits for the computer move, judges the round and keeps BCD scores.
- Feeds the HEX decoders and LEDs.
- Emits a one-cycle history record (user move, computer move) for the Markov/reinforcement predictors to update on.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles start_n must be stable before a level change is accepted (10 ms at 50 MHz).
- COM_TIMEOUT, 1024: max cycles to wait for com_valid after com_req.
- FALLBACK_MOVE, 2'b00: computer move used on timeout (rock).

Ports:
- clock  input  1  system clock (CLOCK_50 domain)
- reset  input  1  synchronous, active-high reset
- start_n  input  1  raw start key, active-low, asynchronous to clock
- user  input  2  user move: 00 rock, 01 scissor, 10 paper, 11 invalid
- com_req  output  1  level, high while awaiting computer move
- com_valid  input  1  computer move valid; sampled only while com_req=1
- com  input  2  computer move, same encoding as user
- com_shown  output  2  computer move of last judged round
- user_shown  output  2  user move of last judged round
- user_score  output  8  BCD, [7:4] tens, [3:0] units
- com_score  output  8  BCD, same format
- uwin, cwin, draw  output  1 each  result of last judged round; one-hot or all zero
- invalid  output  1  last press rejected (user=11, or com=11 received)
- timeout  output  1  last round used FALLBACK_MOVE
- round_done  output  1  one-cycle pulse when scores/results update
- hist_valid  output  1  one-cycle pulse, coincident with round_done
- hist_user, hist_com  output  2 each  move pair for predictor update; held until the next hist_valid

Behaviour:
Reset:
- All outputs 0; FSM in IDLE.
- Debounced key state = released (1); sync flops = 1.
- Reset mid-operation aborts the round: com_req drops the next cycle and no score changes.

Input conditioning:
- start_n passes through a 2-flop synchroniser.
- A counter reloads whenever the synchronised value equals the debounced state. It counts when they differ, and the debounced state flips when the count reaches DEBOUNCE_CYCLES-1.
- press = debounced 1->0 transition, a one-cycle internal pulse.
- Latency from a stable raw edge to press: 2 + DEBOUNCE_CYCLES cycles.

FSM states: IDLE, REQ, JUDGE, SHOW.
- IDLE
  - On press: latch user into u_lat.
  - If user=11: set invalid=1, clear timeout, stay in IDLE. Scores and results are unchanged.
  - Otherwise: clear invalid and timeout, go to REQ.
- REQ
  - com_req=1 and a wait counter runs.
  - On com_valid=1 with com≠11: latch c_lat=com, go to JUDGE.
  - On com_valid=1 with com=11: set invalid=1, drop com_req, return to IDLE.
  - If the counter hits COM_TIMEOUT-1 without com_valid: set c_lat=FALLBACK_MOVE and timeout=1, go to JUDGE.
  - If com_valid and the timeout occur in the same cycle, com_valid wins.
  - Presses in REQ are ignored.
  - com_req deasserts the cycle after acceptance.
- JUDGE (exactly one cycle)
  - Wins: user wins when (u,c) ∈ {(00,01),(01,10),(10,00)}; equal moves are a draw; otherwise the computer wins.
  - Update uwin/cwin/draw, user_shown=u_lat, com_shown=c_lat.
  - Increment the winner's BCD score: units 9 -> 0 with tens+1; 99 saturates at 99.
  - Pulse round_done and hist_valid; load hist_user/hist_com.
  - Go to SHOW.
- SHOW
  - Wait for the debounced key to be released (1), then go to IDLE.
  - This guarantees one round per press.
  - Results persist until the next judged round or a reset.

Latency:
- press to round_done = 2 cycles minimum (com_valid already high when REQ is entered).
- Worst case = COM_TIMEOUT+1 cycles.

Decomposition:
- Shared package rps_pkg:
  - move constants ROCK=2'b00, SCISSOR=2'b01, PAPER=2'b10, INVALID=2'b11.
  - Referee state encoding.
  - Function beats(a,b) returning 1 when move a beats b.
- Sub-module key_debounce (synchroniser + counter + falling-edge pulse), parameterised by DEBOUNCE_CYCLES. It is reusable for the other KEY inputs.
- BCD score increment is a function in rps_pkg, not a module.

Test Plan (DEBOUNCE_CYCLES=4, COM_TIMEOUT=8):
- Reset, then press with user=00, com_valid=1 and com=01 in the REQ cycle -> round_done after 2 cycles; uwin=1, user_score=8'h01, com_score=8'h00, hist_user=00, hist_com=01.
- start_n glitch low for 3 cycles -> no press, com_req stays 0. Held low 6+ cycles -> exactly one round; holding 100 more cycles -> no second round.
- user=11 and press -> invalid=1, com_req never asserts, scores unchanged. Then user=10, com=10 -> draw=1, invalid=0, scores unchanged.
- Press with com_valid held 0 -> com_req high for 8 cycles, then timeout=1 and com_shown=00. User=10 -> uwin=1.
- Preload user_score=8'h09 by 9 user wins, then one more win -> 8'h10. Continue to 8'h99, then one more win -> stays 8'h99.
- Assert reset while in REQ -> next cycle com_req=0 and all outputs 0. A late com_valid pulse is ignored and no round_done occurs.
